rr_grant_sched8: RTL and testbench



---
 rtl/rr_grant_sched8_pkg.sv | 23 ++
 rtl/rr_grant_sched8_pick8.sv | 45 ++++
 rtl/rr_grant_sched8.sv | 115 +++++++++++
 tb/tb_rr_grant_sched8.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/rr_grant_sched8_pkg.sv
// ============================================================================
// Module   : rr_grant_sched8_pkg
// Brief    : Shared types and constants for the 8-way round-robin scheduler.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package rr_grant_sched8_pkg;

    localparam int N_REQ  = 8;
    localparam int CODE_W = 3;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    typedef enum logic [0:0] {
        IDLE  = ST_IDLE,
        GRANT = ST_GRANT
    } state_e;

endpackage

`default_nettype wire

// File: rtl/rr_grant_sched8_pick8.sv
// ============================================================================
// Module   : rr_pick8
// Brief    : Round-robin picker: first requester at or after ptr, wrapping.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick8
    import rr_grant_sched8_pkg::*;
(
    input  logic [N_REQ-1:0]  req,
    input  logic [CODE_W-1:0] ptr,
    output logic              any,
    output logic [CODE_W-1:0] winner
);

    logic [N_REQ-1:0]  w_rot;
    logic [CODE_W-1:0] w_off;
    logic [CODE_W-1:0] w_idx;

    // Rotate so that ptr lands on bit 0; index arithmetic wraps mod 8.
    always_comb begin
        w_rot = '0;
        w_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_idx    = ptr + CODE_W'(i);
            w_rot[i] = req[w_idx];
        end
    end

    always_comb begin
        w_off = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_off = CODE_W'(i);
            end
        end
    end

    assign any    = |req;
    assign winner = w_off + ptr;

endmodule

`default_nettype wire

// File: rtl/rr_grant_sched8.sv
// ============================================================================
// Module   : rr_grant_sched8
// Brief    : Round-robin grant sequencer with hold limit and forced preemption.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_grant_sched8
    import rr_grant_sched8_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_REQ-1:0]  req,
    output logic              grant_valid,
    output logic [CODE_W-1:0] grant_code,
    output logic [N_REQ-1:0]  grant_onehot,
    output logic              preempt
);

    localparam logic [CNT_W-1:0] C_HOLD_LIMIT = CNT_W'(MAX_HOLD);
    localparam logic [CNT_W-1:0] C_CNT_SAT    = '1;
    localparam logic [CNT_W-1:0] C_CNT_ONE    = CNT_W'(1);
    localparam bit               C_LIMIT_EN   = (MAX_HOLD != 0);

    generate
        if ((64'd1 << CNT_W) <= 64'(MAX_HOLD)) begin : g_bad_cnt_w
            $error("rr_grant_sched8: CNT_W too narrow for MAX_HOLD");
        end
    endgenerate

    state_e            state_q,    state_d;
    logic [CODE_W-1:0] ptr_q,      ptr_d;
    logic [CODE_W-1:0] code_q,     code_d;
    logic [CNT_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic              preempt_q,  preempt_d;

    logic              w_any;
    logic [CODE_W-1:0] w_winner;
    logic              w_owner_req;

    rr_pick8 u_pick (
        .req    (req),
        .ptr    (ptr_q),
        .any    (w_any),
        .winner (w_winner)
    );

    // While granted, only the owner's request line matters.
    assign w_owner_req = req[code_q];

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        code_d     = code_q;
        hold_cnt_d = hold_cnt_q;
        preempt_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (w_any) begin
                    state_d    = GRANT;
                    code_d     = w_winner;
                    hold_cnt_d = C_CNT_ONE;
                end
            end
            GRANT: begin
                if (!w_owner_req) begin
                    state_d = IDLE;
                    ptr_d   = code_q + CODE_W'(1);
                end else if (C_LIMIT_EN && (hold_cnt_q == C_HOLD_LIMIT)) begin
                    state_d   = IDLE;
                    ptr_d     = code_q + CODE_W'(1);
                    preempt_d = 1'b1;
                end else if (hold_cnt_q != C_CNT_SAT) begin
                    hold_cnt_d = hold_cnt_q + C_CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            code_q     <= '0;
            hold_cnt_q <= '0;
            preempt_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            code_q     <= code_d;
            hold_cnt_q <= hold_cnt_d;
            preempt_q  <= preempt_d;
        end
    end

    assign grant_valid = (state_q == GRANT);
    assign grant_code  = code_q;
    assign preempt     = preempt_q;

    // Gated decode: a stale code never reaches the select lines.
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_onehot
            assign grant_onehot[gi] = grant_valid && (code_q == CODE_W'(gi));
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_rr_grant_sched8.sv
// ============================================================================
// Module   : tb_rr_grant_sched8
// Brief    : Directed and random checks of rr_grant_sched8 against a reference.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rr_grant_sched8;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;

    logic       v16, v4, p16, p4;
    logic [2:0] c16, c4;
    logic [7:0] oh16, oh4;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state per instance: 0 = MAX_HOLD 16, 1 = MAX_HOLD 4
    int lim[2] = '{16, 4};
    int sat[2] = '{31, 7};
    int m_busy[2], m_code[2], m_ten[2], m_start[2], m_pre[2];

    always #5 clk = ~clk;

    rr_grant_sched8 #(.MAX_HOLD(16), .CNT_W(5)) dut16 (
        .clk(clk), .rst(rst), .req(req),
        .grant_valid(v16), .grant_code(c16), .grant_onehot(oh16), .preempt(p16)
    );

    rr_grant_sched8 #(.MAX_HOLD(4), .CNT_W(3)) dut4 (
        .clk(clk), .rst(rst), .req(req),
        .grant_valid(v4), .grant_code(c4), .grant_onehot(oh4), .preempt(p4)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input int n);
        int idx;
        if (rst) begin
            m_busy[n] = 0; m_code[n] = 0; m_ten[n] = 0; m_start[n] = 0; m_pre[n] = 0;
        end else if (m_busy[n] == 0) begin
            m_pre[n] = 0;
            if (req != 8'h00) begin
                for (int off = 7; off >= 0; off--) begin
                    idx = (m_start[n] + off) % 8;
                    if (req[idx]) m_code[n] = idx;
                end
                m_busy[n] = 1;
                m_ten[n]  = 1;
            end
        end else begin
            m_pre[n] = 0;
            if (!req[m_code[n]]) begin
                m_busy[n]  = 0;
                m_start[n] = (m_code[n] + 1) % 8;
            end else if (lim[n] != 0 && m_ten[n] == lim[n]) begin
                m_busy[n]  = 0;
                m_start[n] = (m_code[n] + 1) % 8;
                m_pre[n]   = 1;
            end else if (m_ten[n] < sat[n]) begin
                m_ten[n]++;
            end
        end
    endtask

    function automatic logic [7:0] exp_onehot(input int n);
        return (m_busy[n] != 0) ? (8'h01 << m_code[n]) : 8'h00;
    endfunction

    // One clock: advance the reference with the inputs seen at the edge, then compare.
    task automatic tick();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        chk("valid16",  32'(v16),  32'(m_busy[0]));
        chk("code16",   32'(c16),  32'(m_code[0]));
        chk("onehot16", 32'(oh16), 32'(exp_onehot(0)));
        chk("preempt16", 32'(p16), 32'(m_pre[0]));
        chk("valid4",   32'(v4),   32'(m_busy[1]));
        chk("code4",    32'(c4),   32'(m_code[1]));
        chk("onehot4",  32'(oh4),  32'(exp_onehot(1)));
        chk("preempt4", 32'(p4),   32'(m_pre[1]));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 8'h00;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0] drop;
        rst = 1'b1;
        req = 8'h00;
        for (int n = 0; n < 2; n++) begin
            m_busy[n] = 0; m_code[n] = 0; m_ten[n] = 0; m_start[n] = 0; m_pre[n] = 0;
        end
        tick();
        tick();
        chk("rst_valid",  32'(v16),  32'd0);
        chk("rst_code",   32'(c16),  32'd0);
        chk("rst_onehot", 32'(oh16), 32'h00);
        chk("rst_preempt", 32'(p16), 32'd0);
        rst = 1'b0;

        // Idle with no requests
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_valid",  32'(v16 | v4),  32'd0);
            chk("idle_onehot", 32'(oh16 | oh4), 32'h00);
        end

        // Two requesters, lowest index first from ptr=0
        do_reset();
        req = 8'b0000_0101;
        tick();
        chk("pair_code0",   32'(c16),  32'd0);
        chk("pair_onehot0", 32'(oh16), 32'h01);
        req = 8'b0000_0100;
        tick();
        chk("pair_gap", 32'(v16), 32'd0);
        tick();
        chk("pair_code2",   32'(c16),  32'd2);
        chk("pair_onehot2", 32'(oh16), 32'h04);

        // All requesting: rotation 0..7 then wrap to 0, one idle cycle between
        do_reset();
        for (int k = 0; k < 9; k++) begin
            req = 8'hFF;
            tick();
            chk("rot_valid", 32'(v16), 32'd1);
            chk("rot_code",  32'(c16), 32'(k % 8));
            tick();
            drop = 8'hFF & ~(8'h01 << (k % 8));
            req = drop;
            tick();
            chk("rot_gap", 32'(v16), 32'd0);
        end

        // Hold limit of 4 with a single persistent requester
        do_reset();
        req = 8'h20;
        for (int rep = 0; rep < 3; rep++) begin
            for (int j = 0; j < 4; j++) begin
                tick();
                chk("hold_valid", 32'(v4), 32'd1);
                chk("hold_code",  32'(c4), 32'd5);
                if (j == 0) chk("hold_nopre", 32'(p4), 32'd0);
            end
            tick();
            chk("hold_gap", 32'(v4), 32'd0);
            chk("hold_pre", 32'(p4), 32'd1);
        end

        // Previous holder 3 gets lowest priority after its release
        do_reset();
        req = 8'h08;
        tick();
        chk("prio_code3", 32'(c16), 32'd3);
        req = 8'h00;
        tick();
        req = 8'b0100_1000;
        tick();
        chk("prio_code6", 32'(c16), 32'd6);
        req = 8'h08;
        tick();
        chk("prio_gap", 32'(v16), 32'd0);
        tick();
        chk("prio_back3", 32'(c16), 32'd3);

        // Reset mid-grant drops the grant and returns ptr to 0
        do_reset();
        req = 8'h08;
        tick();
        chk("mid_code3", 32'(c16), 32'd3);
        rst = 1'b1;
        tick();
        chk("mid_valid", 32'(v16), 32'd0);
        rst = 1'b0;
        req = 8'h09;
        tick();
        chk("mid_code0", 32'(c16), 32'd0);

        // Random traffic with occasional resets
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 7) == 0) req = 8'($urandom);
            if ($urandom_range(0, 15) == 0) req[$urandom_range(0, 7)] = 1'($urandom);
            rst = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
